sn74hc4017: RTL and testbench
=============================

Name: sn74hc4017

Overview:
- Behavioural model of the '4017 decade counter/divider: a 5-stage Johnson counter with 10 one-hot decoded outputs and a carry output.
- Sits directly upstream of the sn74175 quad D FF on the board. Decoded outputs provide the sequenced strobes driving the FF clock (pin 9) and clear (pin 1); carry out provides the divide-by-10 phase.
- Pin-numbered ports, 16-pin package. P8 = GND and P16 = VCC gate all non-reset behaviour.

Parameters:
- None. Fixed-function part.

Ports:
- P14  input  1  CP0, clock; counter advances on rising edge
- P15  input  1  MR, master reset; asynchronous, active-high
- P13  input  1  CP1, count enable, active-low, sampled at rising edge of P14
- P16  input  1  VCC; behaviour enabled only when 1
- P8   input  1  GND; behaviour enabled only when 0
- P3   output 1  Q0
- P2   output 1  Q1
- P4   output 1  Q2
- P7   output 1  Q3
- P10  output 1  Q4
- P1   output 1  Q5
- P5   output 1  Q6
- P6   output 1  Q7
- P9   output 1  Q8
- P11  output 1  Q9
- P12  output 1  CO, carry out; 1 for counts 0-4, 0 for counts 5-9

Behaviour:
- Clock and reset: one clock, P14, rising edge; reset P15, asynchronous, active-high.
- State: internal 5-bit Johnson register J[4:0]. Legal sequence: 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000, then back to 00000. These are counts 0-9.
- Reset: P15 high immediately forces J = 00000, independent of clock, P13 and power pins.
  - Outputs under reset: Q0 = 1, Q1-Q9 = 0, CO = 1.
  - While P15 is high, P14 edges are ignored.
  - First count after release occurs on the first P14 rising edge with P15 low.
- Power gating: if P16 != 1 or P8 != 0, J holds on clock edges; outputs keep last values; reset still acts.
- Count: on P14 rising edge with P15 = 0, P13 = 0 and power valid, J shifts left with bit0 <= ~J[4].
  - One count per edge.
  - Count 9 to count 0 wrap is seamless; no dead cycle.
- Hold: P13 = 1 at the edge holds J.
- Self-correction: any of the 22 illegal J patterns seen at a counting edge loads J = 00000 (count 0). Covers X/unknown power-up state once reset or a counting edge occurs.
- Decode:
  - Outputs are combinational from J, zero latency after the state change.
  - Exactly one of Q0-Q9 is high in any legal state.
  - Illegal state drives all Q0-Q9 low; CO = ~J[4].
- CO: equals ~J[4]. It rises on the 9 to 0 transition, which gives a divide-by-10 square wave at 50% duty.
- Simultaneous events: reset asserted on the same timestep as a clock edge resolves to count 0.
- Reset mid-count: count is discarded; there is no resume.

Decomposition:
- Shared include file holds:
  - the legal Johnson state constants JS0-JS9 (5-bit)
  - a COUNT_MAX = 9 localparam
  - pin-role comments table constants
- One sub-module is natural: sn74hc4017_decode, a pure combinational 5-bit Johnson to 10-line one-hot plus CO decoder, instantiated once.
- The state register and correction logic stay in the top module.

Test Plan:
- Power valid, pulse P15, release, 0 clocks -> P3 = 1, all other Q = 0, P12 = 1.
- 10 clocks with P13 = 0 -> one-hot walks Q0, Q1, ..., Q9; after edge 10, Q0 = 1 again. P12 = 0 exactly after edges 5-9 and returns to 1 at edge 10.
- Clock to count 3, set P13 = 1, apply 4 clocks -> P7 (Q3) stays 1. Clear P13, 1 clock -> P10 (Q4) = 1.
- At count 6, assert P15 between edges -> Q0 = 1 immediately, with no clock edge needed. Clock with P15 held high -> still count 0.
- Force J = 01010 via hierarchical deposit, apply 1 clock -> count 0 (Q0 = 1). Before the clock, all Q = 0 and P12 = 1.
- Set P16 = 0 at count 2, apply 3 clocks -> P4 (Q2) stays 1. Restore P16 = 1, 1 clock -> Q3 = 1.

Source files
------------

// File: rtl/sn74hc4017_pkg.sv
// Shared constants for the '4017 decade counter model.
// Holds the ten legal Johnson states, the terminal count, the pin-role map of
// the 16-pin package, and a legality helper used by the self-correction logic.
package sn74hc4017_pkg;

    // Legal Johnson sequence, counts 0..9
    localparam logic [4:0] JS0 = 5'b00000;
    localparam logic [4:0] JS1 = 5'b00001;
    localparam logic [4:0] JS2 = 5'b00011;
    localparam logic [4:0] JS3 = 5'b00111;
    localparam logic [4:0] JS4 = 5'b01111;
    localparam logic [4:0] JS5 = 5'b11111;
    localparam logic [4:0] JS6 = 5'b11110;
    localparam logic [4:0] JS7 = 5'b11100;
    localparam logic [4:0] JS8 = 5'b11000;
    localparam logic [4:0] JS9 = 5'b10000;

    localparam int COUNT_MAX = 9;

    // Pin-role table (package pin numbers)
    localparam int PIN_CP0 = 14;  // clock
    localparam int PIN_MR  = 15;  // master reset
    localparam int PIN_CP1 = 13;  // count enable, active-low
    localparam int PIN_VCC = 16;
    localparam int PIN_GND = 8;
    localparam int PIN_CO  = 12;  // carry out

    // Unknown bits never match a case item, so X state reads as illegal.
    function automatic logic is_legal(input logic [4:0] j);
        case (j)
            JS0, JS1, JS2, JS3, JS4,
            JS5, JS6, JS7, JS8, JS9: is_legal = 1'b1;
            default:                 is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sn74hc4017_if.sv
// Pin bundle for the '4017: count enable, supply pins and the eleven outputs.
// master: board side (drives CP1/VCC/GND, reads outputs)
// slave : the counter device
interface sn74hc4017_if;
    logic P13;  // CP1, count enable, active-low
    logic P16;  // VCC
    logic P8;   // GND
    logic P3;   // Q0
    logic P2;   // Q1
    logic P4;   // Q2
    logic P7;   // Q3
    logic P10;  // Q4
    logic P1;   // Q5
    logic P5;   // Q6
    logic P6;   // Q7
    logic P9;   // Q8
    logic P11;  // Q9
    logic P12;  // CO

    modport master (
        output P13, P16, P8,
        input  P3, P2, P4, P7, P10, P1, P5, P6, P9, P11, P12
    );

    modport slave (
        input  P13, P16, P8,
        output P3, P2, P4, P7, P10, P1, P5, P6, P9, P11, P12
    );
endinterface

// File: rtl/sn74hc4017_decode.sv
// Combinational Johnson-to-decimal decoder.
// Ports: j  - 5-bit Johnson state
//        q  - one-hot count 0..9 (all low for an illegal state)
//        co - carry out, high for counts 0..4
module sn74hc4017_decode
    import sn74hc4017_pkg::*;
(
    input  logic [4:0] j,
    output logic [9:0] q,
    output logic       co
);

    always_comb begin
        q = '0;
        case (j)
            JS0: q[0] = 1'b1;
            JS1: q[1] = 1'b1;
            JS2: q[2] = 1'b1;
            JS3: q[3] = 1'b1;
            JS4: q[4] = 1'b1;
            JS5: q[5] = 1'b1;
            JS6: q[6] = 1'b1;
            JS7: q[7] = 1'b1;
            JS8: q[8] = 1'b1;
            JS9: q[9] = 1'b1;
            default: q = '0;
        endcase
    end

    // J[4] is low for counts 0-4 and high for 5-9: a 50% duty divide-by-10.
    assign co = ~j[4];

endmodule

// File: rtl/sn74hc4017.sv
// '4017 decade counter/divider: 5-stage Johnson counter, ten decoded outputs
// and carry out.
// Ports: P14  - CP0 clock, rising edge
//        P15  - MR, asynchronous active-high reset (forces count 0)
//        pins - CP1 enable, VCC/GND gating, Q0..Q9 and CO
module sn74hc4017
    import sn74hc4017_pkg::*;
(
    input  logic P14,
    input  logic P15,
    sn74hc4017_if.slave pins
);

    logic [4:0] j_q, j_d;
    logic [9:0] q;
    logic       co;
    logic       pwr_ok;

    assign pwr_ok = (pins.P16 === 1'b1) && (pins.P8 === 1'b0);

    always_comb begin
        j_d = j_q;
        if (pwr_ok && (pins.P13 == 1'b0)) begin
            // An illegal (or unknown) pattern at a counting edge recovers to count 0.
            if (is_legal(j_q))
                j_d = {j_q[3:0], ~j_q[4]};
            else
                j_d = JS0;
        end
    end

    // Reset on the async branch wins over a coincident clock edge.
    always_ff @(posedge P14 or posedge P15) begin
        if (P15)
            j_q <= JS0;
        else
            j_q <= j_d;
    end

    sn74hc4017_decode u_decode (
        .j  (j_q),
        .q  (q),
        .co (co)
    );

    assign pins.P3  = q[0];
    assign pins.P2  = q[1];
    assign pins.P4  = q[2];
    assign pins.P7  = q[3];
    assign pins.P10 = q[4];
    assign pins.P1  = q[5];
    assign pins.P5  = q[6];
    assign pins.P6  = q[7];
    assign pins.P9  = q[8];
    assign pins.P11 = q[9];
    assign pins.P12 = co;

endmodule

// File: tb/tb_sn74hc4017.sv
// Directed bench for the '4017 model: a vector table walked in order, plus
// hand-written sequences for reset, simultaneous edges and illegal states.
module tb_sn74hc4017;

    typedef struct {
        string      name;
        logic       p13;
        logic       p16;
        logic       p8;
        int         nclk;
        logic [9:0] q;
        logic       co;
    } vec_t;

    logic P14;
    logic P15;
    int   errors;
    int   checks;
    vec_t vq[$];

    sn74hc4017_if pins ();

    sn74hc4017 dut (
        .P14  (P14),
        .P15  (P15),
        .pins (pins)
    );

    function automatic vec_t mk(string n, logic p13, logic p16, logic p8,
                                int nclk, logic [9:0] q, logic co);
        vec_t v;
        v.name = n; v.p13 = p13; v.p16 = p16; v.p8 = p8;
        v.nclk = nclk; v.q = q; v.co = co;
        return v;
    endfunction

    task automatic tick();
        P14 = 1'b1; #5;
        P14 = 1'b0; #5;
    endtask

    task automatic pulse_reset();
        P15 = 1'b1; #5;
        P15 = 1'b0; #5;
    endtask

    task automatic chk(string name, logic [9:0] eq, logic eco);
        logic [9:0] got;
        got = {pins.P11, pins.P9, pins.P6, pins.P5, pins.P1,
               pins.P10, pins.P7, pins.P4, pins.P2, pins.P3};
        checks++;
        if (got !== eq || pins.P12 !== eco) begin
            errors++;
            $display("FAIL %s: got q=%b co=%b, expected q=%b co=%b",
                     name, got, pins.P12, eq, eco);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        P14      = 1'b0;
        P15      = 1'b0;
        pins.P13 = 1'b0;
        pins.P16 = 1'b1;
        pins.P8  = 1'b0;
        #3;

        // Reset state, no clocks
        pulse_reset();
        chk("reset_state", 10'b0000000001, 1'b1);

        // Full decade walk, then hold, then power gating
        vq.push_back(mk("walk1", 0, 1, 0, 1, 10'b0000000010, 1));
        vq.push_back(mk("walk2", 0, 1, 0, 1, 10'b0000000100, 1));
        vq.push_back(mk("walk3", 0, 1, 0, 1, 10'b0000001000, 1));
        vq.push_back(mk("walk4", 0, 1, 0, 1, 10'b0000010000, 1));
        vq.push_back(mk("walk5", 0, 1, 0, 1, 10'b0000100000, 0));
        vq.push_back(mk("walk6", 0, 1, 0, 1, 10'b0001000000, 0));
        vq.push_back(mk("walk7", 0, 1, 0, 1, 10'b0010000000, 0));
        vq.push_back(mk("walk8", 0, 1, 0, 1, 10'b0100000000, 0));
        vq.push_back(mk("walk9", 0, 1, 0, 1, 10'b1000000000, 0));
        vq.push_back(mk("wrap0", 0, 1, 0, 1, 10'b0000000001, 1));
        vq.push_back(mk("to3",   0, 1, 0, 3, 10'b0000001000, 1));
        vq.push_back(mk("hold3", 1, 1, 0, 4, 10'b0000001000, 1));
        vq.push_back(mk("rel4",  0, 1, 0, 1, 10'b0000010000, 1));
        vq.push_back(mk("to2",   0, 1, 0, 8, 10'b0000000100, 1));
        vq.push_back(mk("vcc0",  0, 0, 0, 3, 10'b0000000100, 1));
        vq.push_back(mk("gnd1",  0, 1, 1, 2, 10'b0000000100, 1));
        vq.push_back(mk("pwr3",  0, 1, 0, 1, 10'b0000001000, 1));

        foreach (vq[i]) begin
            pins.P13 = vq[i].p13;
            pins.P16 = vq[i].p16;
            pins.P8  = vq[i].p8;
            for (int c = 0; c < vq[i].nclk; c++) tick();
            chk(vq[i].name, vq[i].q, vq[i].co);
        end
        pins.P13 = 1'b0; pins.P16 = 1'b1; pins.P8 = 1'b0;

        // Reset mid-count at 6: immediate, clocks ignored while held, no resume
        pulse_reset();
        for (int c = 0; c < 6; c++) tick();
        chk("at6", 10'b0001000000, 1'b0);
        P15 = 1'b1; #2;
        chk("mr_async", 10'b0000000001, 1'b1);
        tick();
        chk("mr_held_clk", 10'b0000000001, 1'b1);
        P15 = 1'b0; #2;
        tick();
        chk("mr_release", 10'b0000000010, 1'b1);

        // Reset even with power invalid
        pins.P16 = 1'b0;
        pulse_reset();
        chk("mr_unpowered", 10'b0000000001, 1'b1);
        pins.P16 = 1'b1;

        // Reset and clock rising in the same timestep
        tick(); tick();
        P15 = 1'b1; P14 = 1'b1; #5;
        P14 = 1'b0; P15 = 1'b0; #5;
        chk("mr_clk_same", 10'b0000000001, 1'b1);

        // Illegal 01010: all Q low, CO = ~J4 = 1, corrected on next count
        force dut.j_q = 5'b01010;
        #1;
        release dut.j_q;
        #1;
        chk("illegal_01010", 10'b0000000000, 1'b1);
        tick();
        chk("fix_01010", 10'b0000000001, 1'b1);

        // Illegal 10101 held by CP1 high, corrected once counting resumes
        force dut.j_q = 5'b10101;
        #1;
        release dut.j_q;
        #1;
        pins.P13 = 1'b1;
        tick();
        chk("illegal_hold", 10'b0000000000, 1'b0);
        pins.P13 = 1'b0;
        tick();
        chk("fix_10101", 10'b0000000001, 1'b1);
        tick();
        chk("after_fix", 10'b0000000010, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
